// File: rtl/sips4_input_conditioner.sv
// SIPS4 input front end: per-lane synchroniser and debouncer for the slide switches and
// push buttons, plus registered press pulses and software-clearable sticky press flags.
module sips4_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned CNT_W             = 19,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] slide_raw,
  input  logic [1:0] button_raw,
  input  logic [1:0] press_ack,
  output logic [3:0] slide_q,
  output logic [1:0] button_q,
  output logic [1:0] press_pulse,
  output logic [1:0] press_flag
);

  localparam int unsigned NumLanes = 6;

  // Raw pin level that means "inactive"; also the polarity flip applied after syncing.
  localparam logic [NumLanes-1:0] InactiveRaw = {{2{BUTTON_ACTIVE_LOW}}, 4'b0000};
  localparam logic [CNT_W-1:0]    CntLast     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CntOne      = CNT_W'(1);

  logic [NumLanes-1:0] raw;
  logic [NumLanes-1:0] synced;

  logic [NumLanes-1:0] sync_d [SYNC_STAGES];
  logic [NumLanes-1:0] sync_q [SYNC_STAGES];

  logic [CNT_W-1:0]    cnt_d  [NumLanes];
  logic [CNT_W-1:0]    cnt_q  [NumLanes];
  logic [NumLanes-1:0] lvl_d, lvl_q;

  logic [1:0] btn_prev_d, btn_prev_q;
  logic [1:0] pulse_d, pulse_q;
  logic [1:0] flag_d, flag_q;

  assign raw = {button_raw, slide_raw};

  // Synchroniser chain
  always_comb begin
    sync_d[0] = raw;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= InactiveRaw;
      end
    end else begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign synced = sync_q[SYNC_STAGES-1] ^ InactiveRaw;

  // Debounce: a zero count means the lane is stable, non-zero means a change is pending.
  always_comb begin
    lvl_d = lvl_q;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] == '0) begin
        if (synced[i] != lvl_q[i]) begin
          cnt_d[i] = CntOne;
        end
      end else if (synced[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        lvl_d[i] = synced[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      for (int unsigned i = 0; i < NumLanes; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      lvl_q <= lvl_d;
      for (int unsigned i = 0; i < NumLanes; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Press events follow the debounced level by one cycle; set beats ack on the flag.
  always_comb begin
    btn_prev_d = lvl_q[5:4];
    pulse_d    = lvl_q[5:4] & ~btn_prev_q;
    flag_d     = pulse_q | (flag_q & ~press_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= '0;
      pulse_q    <= '0;
      flag_q     <= '0;
    end else begin
      btn_prev_q <= btn_prev_d;
      pulse_q    <= pulse_d;
      flag_q     <= flag_d;
    end
  end

  assign slide_q     = lvl_q[3:0];
  assign button_q    = lvl_q[5:4];
  assign press_pulse = pulse_q;
  assign press_flag  = flag_q;

endmodule

// File: tb/tb_sips4_input_conditioner.sv
// Directed table-driven bench for sips4_input_conditioner with a short debounce window.
module tb_sips4_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] slide_raw;
  logic [1:0] button_raw;
  logic [1:0] press_ack;
  logic [3:0] slide_q;
  logic [1:0] button_q;
  logic [1:0] press_pulse;
  logic [1:0] press_flag;

  always #5 clk = ~clk;

  sips4_input_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .CNT_W            (3),
    .SYNC_STAGES      (2),
    .BUTTON_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .slide_raw  (slide_raw),
    .button_raw (button_raw),
    .press_ack  (press_ack),
    .slide_q    (slide_q),
    .button_q   (button_q),
    .press_pulse(press_pulse),
    .press_flag (press_flag)
  );

  typedef struct {
    logic [3:0] slide;
    logic [1:0] button;
    logic [1:0] ack;
    logic [3:0] e_slide;
    logic [1:0] e_button;
    logic [1:0] e_pulse;
    logic [1:0] e_flag;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic add(input logic [3:0] s, input logic [1:0] b, input logic [1:0] a,
                     input logic [3:0] es, input logic [1:0] eb, input logic [1:0] ep,
                     input logic [1:0] ef);
    vec_t v;
    v.slide    = s;
    v.button   = b;
    v.ack      = a;
    v.e_slide  = es;
    v.e_button = eb;
    v.e_pulse  = ep;
    v.e_flag   = ef;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input logic [3:0] es, input logic [1:0] eb,
                       input logic [1:0] ep, input logic [1:0] ef);
    n_vec++;
    if ({slide_q, button_q, press_pulse, press_flag} !== {es, eb, ep, ef}) begin
      n_mis++;
      $display("FAIL %s: got slide_q=%h button_q=%b press_pulse=%b press_flag=%b, want %h %b %b %b",
               tag, slide_q, button_q, press_pulse, press_flag, es, eb, ep, ef);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: reset with all pins at their "on"/idle levels
    rst_n      = 1'b0;
    slide_raw  = 4'hF;
    button_raw = 2'b11;
    press_ack  = 2'b00;
    #2;
    check("reset_async", 4'h0, 2'b00, 2'b00, 2'b00);
    repeat (3) tick();
    check("reset_hold", 4'h0, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("release_%0d", i), (i >= 6) ? 4'hF : 4'h0, 2'b00, 2'b00, 2'b00);
    end

    // Test 2: slide F -> 0, then 0 -> 5
    for (int k = 1; k <= 6; k++) add(4'h0, 2'b11, 2'b00, (k < 6) ? 4'hF : 4'h0, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 8; k++) add(4'h5, 2'b11, 2'b00, (k < 6) ? 4'h0 : 4'h5, 2'b00, 2'b00, 2'b00);
    // Test 3: three-cycle glitch on button 0
    for (int k = 1; k <= 3; k++) add(4'h5, 2'b10, 2'b00, 4'h5, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 6; k++) add(4'h5, 2'b11, 2'b00, 4'h5, 2'b00, 2'b00, 2'b00);
    // Test 4: long press on button 1, release, then ack
    for (int k = 1; k <= 28; k++)
      add(4'h5, (k <= 20) ? 2'b01 : 2'b11, 2'b00, 4'h5,
          (k >= 6 && k <= 25) ? 2'b10 : 2'b00, (k == 7) ? 2'b10 : 2'b00,
          (k >= 8) ? 2'b10 : 2'b00);
    add(4'h5, 2'b11, 2'b10, 4'h5, 2'b00, 2'b00, 2'b00);
    add(4'h5, 2'b11, 2'b01, 4'h5, 2'b00, 2'b00, 2'b00);  // ack on a clear flag
    add(4'h5, 2'b11, 2'b00, 4'h5, 2'b00, 2'b00, 2'b00);
    // Test 5: press button 0 with ack landing on the pulse cycle
    for (int k = 1; k <= 9; k++)
      add(4'h5, 2'b10, (k == 8) ? 2'b01 : 2'b00, 4'h5, (k >= 6) ? 2'b01 : 2'b00,
          (k == 7) ? 2'b01 : 2'b00, (k >= 8) ? 2'b01 : 2'b00);
    for (int k = 1; k <= 6; k++)
      add(4'h5, 2'b11, 2'b00, 4'h5, (k < 6) ? 2'b01 : 2'b00, 2'b00, 2'b01);
    add(4'h5, 2'b11, 2'b01, 4'h5, 2'b00, 2'b00, 2'b00);

    foreach (vecs[i]) begin
      slide_raw  = vecs[i].slide;
      button_raw = vecs[i].button;
      press_ack  = vecs[i].ack;
      tick();
      check($sformatf("vec%0d", i), vecs[i].e_slide, vecs[i].e_button, vecs[i].e_pulse,
            vecs[i].e_flag);
    end
    press_ack = 2'b00;

    // Test 6: reset in the middle of a slide[3] debounce
    slide_raw = 4'hD;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("pre_rst_%0d", i), 4'h5, 2'b00, 2'b00, 2'b00);
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid", 4'h0, 2'b00, 2'b00, 2'b00);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("restart_%0d", i), (i >= 6) ? 4'hD : 4'h0, 2'b00, 2'b00, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
